// File: rtl/sys_bus_arbiter.sv
// Shared serial bus arbiter: round-robin (or fixed priority when ARB_FIXED_PRIO_EN
// is defined) grant with txn_done / abandon / timeout release and a 1-cycle turnaround.
module sys_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   txn_done,
    output logic [NUM_MASTERS-1:0] grant_onehot,
    output logic [2:0]             grant_id,
    output logic                   bus_busy,
    output logic                   timeout_pulse
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [2:0]             id_nxt;
    logic                   busy_nxt;
    logic                   pulse_nxt;
    logic [15:0]            tmo_cnt, tmo_nxt;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic [2:0]             win_id;
    logic                   found;
    logic                   abandon;
    logic                   tmo_hit;
    int unsigned            idx;

`ifndef ARB_FIXED_PRIO_EN
    logic [2:0] rr_ptr, rr_nxt;
`endif

    // Winner selection uses shifted masks so no variable bit-select is needed.
    always_comb begin
        win_onehot = '0;
        win_id     = '0;
        found      = 1'b0;
        idx        = 0;
`ifdef ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx = i;
            if (!found && |(req & (NUM_MASTERS'(1) << idx))) begin
                found      = 1'b1;
                win_onehot = NUM_MASTERS'(1) << idx;
                win_id     = 3'(idx);
            end
        end
`else
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && |(req & (NUM_MASTERS'(1) << idx))) begin
                found      = 1'b1;
                win_onehot = NUM_MASTERS'(1) << idx;
                win_id     = 3'(idx);
            end
        end
`endif
    end

    assign abandon = ~|(req & grant_onehot);
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_onehot;
        id_nxt    = grant_id;
        busy_nxt  = bus_busy;
        pulse_nxt = 1'b0;
        tmo_nxt   = '0;
`ifndef ARB_FIXED_PRIO_EN
        rr_nxt    = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = BUSY;
                    grant_nxt = win_onehot;
                    id_nxt    = win_id;
                    busy_nxt  = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                    rr_nxt    = win_id;
`endif
                end
            end
            BUSY: begin
                tmo_nxt = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
                if (txn_done || abandon || tmo_hit) begin
                    state_nxt = RELEASE;
                    grant_nxt = '0;
                    busy_nxt  = 1'b0;
                    // Timeout is reported only when nothing else ended the grant.
                    pulse_nxt = !txn_done && !abandon;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant_onehot  <= '0;
            grant_id      <= '0;
            bus_busy      <= 1'b0;
            timeout_pulse <= 1'b0;
            tmo_cnt       <= '0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr        <= 3'(NUM_MASTERS - 1);
`endif
        end else begin
            state         <= state_nxt;
            grant_onehot  <= grant_nxt;
            grant_id      <= id_nxt;
            bus_busy      <= busy_nxt;
            timeout_pulse <= pulse_nxt;
            tmo_cnt       <= tmo_nxt;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr        <= rr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter: ownership-level model compared every cycle,
// plus literal checks for the latency, alternation, timeout, abandon and reset cases.
module tb_sys_bus_arbiter;

    localparam int N = 2;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic         txn_done = 1'b0;
    logic [N-1:0] grant_onehot;
    logic [2:0]   grant_id;
    logic         bus_busy;
    logic         timeout_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    bit compare_on = 1'b0;

    sys_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .req(req), .txn_done(txn_done),
        .grant_onehot(grant_onehot), .grant_id(grant_id),
        .bus_busy(bus_busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: who owns the bus, how long it has held it, and the turnaround gap.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_held  = 0;
    bit m_cool  = 1'b0;
    bit m_pulse = 1'b0;
    bit m_done, m_abandon, m_tmo;

    function automatic int pick(input logic [N-1:0] r, input int last);
        int c;
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++)
            if (((r >> k) & 1) != 0) return k;
`else
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (((r >> c) & 1) != 0) return c;
        end
`endif
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = -1; m_last = N - 1; m_held = 0; m_cool = 0; m_pulse = 0;
        end else if (m_owner >= 0) begin
            m_done    = txn_done;
            m_abandon = ((req >> m_owner) & 1) == 0;
            m_tmo     = (T != 0) && (m_held == T);
            if (m_done || m_abandon || m_tmo) begin
                m_pulse = !m_done && !m_abandon;
                m_owner = -1;
                m_cool  = 1'b1;
            end else begin
                m_pulse = 1'b0;
                m_held++;
            end
        end else if (m_cool) begin
            m_cool  = 1'b0;
            m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (req != '0) begin
                m_owner = pick(req, m_last);
                m_last  = m_owner;
                m_held  = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (compare_on) begin
            check("grant_onehot", grant_onehot, (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
            check("bus_busy", bus_busy, (m_owner >= 0) ? 1 : 0);
            if (m_owner >= 0) check("grant_id", grant_id, m_owner);
            check("timeout_pulse", timeout_pulse, m_pulse);
            check("onehot_or_zero", ($countones(grant_onehot) <= 1) ? 1 : 0, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input int limit, output int waited);
        waited = 0;
        while (!bus_busy && waited < limit) begin
            tick();
            waited++;
        end
        check("wait_busy", bus_busy, 1);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [N-1:0] exp2 [4];
    int w, n;

    initial begin
`ifdef ARB_FIXED_PRIO_EN
        exp2[0] = 2'b01; exp2[1] = 2'b01; exp2[2] = 2'b01; exp2[3] = 2'b01;
`else
        exp2[0] = 2'b01; exp2[1] = 2'b10; exp2[2] = 2'b01; exp2[3] = 2'b10;
`endif
        tick();
        compare_on = 1'b1;
        tick();
        check("rst_grant", grant_onehot, 0);
        check("rst_id", grant_id, 0);
        check("rst_busy", bus_busy, 0);
        check("rst_pulse", timeout_pulse, 0);

        // 1: single request, 1-cycle latency, txn_done ends grant
        do_reset();
        req = 2'b01;
        tick();
        check("t1_grant_first", grant_onehot, 2'b01);
        check("t1_busy_first", bus_busy, 1);
        check("t1_id", grant_id, 0);
        repeat (8) tick();
        txn_done = 1'b1;
        check("t1_grant_last", grant_onehot, 2'b01);
        tick();
        txn_done = 1'b0;
        req = 2'b00;
        check("t1_grant_off", grant_onehot, 2'b00);
        check("t1_busy_off", bus_busy, 0);
        check("t1_no_pulse", timeout_pulse, 0);
        repeat (3) tick();

        // 2: both requesting, done every 8 busy cycles
        do_reset();
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_busy(10, w);
            if (g > 0) check("t2_gap", w, 2);
            check("t2_grant", grant_onehot, exp2[g]);
            repeat (7) tick();
            txn_done = 1'b1;
            tick();
            txn_done = 1'b0;
            if (g == 3) req = 2'b00;
        end
        repeat (3) tick();

        // 3: timeout after T busy cycles
        req = 2'b01;
        wait_busy(10, w);
        n = 0;
        while (bus_busy && n < 40) begin
            n++;
            tick();
        end
        check("t3_busy_cycles", n, T);
        check("t3_pulse", timeout_pulse, 1);
        req = 2'b00;
        tick();
        check("t3_pulse_1cyc", timeout_pulse, 0);
        repeat (2) tick();

        // 4: M1 abandons, M0 granted two cycles later
        req = 2'b10;
        wait_busy(10, w);
        check("t4_grant_m1", grant_onehot, 2'b10);
        repeat (3) tick();
        req = 2'b01;
        tick();
        check("t4_drop", grant_onehot, 2'b00);
        check("t4_no_pulse", timeout_pulse, 0);
        tick();
        check("t4_idle", bus_busy, 0);
        tick();
        check("t4_grant_m0", grant_onehot, 2'b01);
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        req = 2'b00;
        repeat (3) tick();

        // 5: asynchronous reset mid-BUSY
        req = 2'b11;
        wait_busy(10, w);
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        check("t5_grant", grant_onehot, 0);
        check("t5_busy", bus_busy, 0);
        check("t5_id", grant_id, 0);
        check("t5_pulse", timeout_pulse, 0);
        tick();
        reset = 1'b0;
        wait_busy(10, w);
        check("t5_first_m0", grant_onehot, 2'b01);
        repeat (3) tick();
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        req = 2'b00;
        repeat (4) tick();

        compare_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
